// File: rtl/comp_task_scheduler_if.sv
// comp_task_scheduler_if: offer/ack and busy handshake between scheduler and comparator
// master (scheduler): drives sched_valid, sched_task_id, sched_busy; samples sched_ack, comp_done
// slave (comparator): samples the offer and busy flag; drives sched_ack, comp_done
interface comp_task_scheduler_if #(parameter int TASK_ID_W = 4);
  logic                 sched_valid;
  logic [TASK_ID_W-1:0] sched_task_id;
  logic                 sched_ack;
  logic                 comp_done;
  logic                 sched_busy;
  modport master(output sched_valid, sched_task_id, sched_busy, input sched_ack, comp_done);
  modport slave(input sched_valid, sched_task_id, sched_busy, output sched_ack, comp_done);
endinterface

// File: rtl/comp_task_scheduler.sv
// comp_task_scheduler: round-robin task picker for the fingerprint comparator with busy watchdog
// ports: clk, reset_n (sync, active-low); task_enable/oflow_fprints_ready/fprint_checkin form the
// request vector; sched (master) carries the offer/ack/done/busy handshake; sched_timeout is a
// sticky watchdog flag cleared by timeout_clear; sched_grant_count counts accepted grants.
// GRANT_MAX sets the saturation point of the grant counter.
module comp_task_scheduler #(
  parameter int          NUM_TASKS      = 16,
  parameter int          TASK_ID_W      = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          TIMER_W        = 11,
  parameter logic [15:0] GRANT_MAX      = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_TASKS-1:0]  task_enable,
  input  logic [NUM_TASKS-1:0]  oflow_fprints_ready,
  input  logic [NUM_TASKS-1:0]  fprint_checkin,
  comp_task_scheduler_if.master sched,
  output logic                  sched_timeout,
  input  logic                  timeout_clear,
  output logic [15:0]           sched_grant_count
);
  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;
  state_t state, state_n;
  logic [NUM_TASKS-1:0] req;
  logic [TASK_ID_W-1:0] rr_ptr, rr_ptr_n, task_id, task_id_n, winner, idx;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [15:0] cnt_n;
  logic timeout_n;
  assign req = task_enable & (oflow_fprints_ready | fprint_checkin);
  assign sched.sched_valid = state == OFFER;
  assign sched.sched_busy = state == BUSY;
  assign sched.sched_task_id = task_id;
  // scan offsets high to low so the smallest offset from rr_ptr is the last (winning) assignment
  always_comb begin
    winner = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_TASKS - 1; k >= 0; k--) begin
      idx = rr_ptr + TASK_ID_W'(k);
      if (req[idx]) winner = idx;
    end
  end
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    task_id_n = task_id;
    timer_n = timer;
    cnt_n = sched_grant_count;
    timeout_n = sched_timeout & ~timeout_clear;
    case (state)
      IDLE: begin
        state_n = |req ? OFFER : IDLE;
        task_id_n = |req ? winner : task_id;
      end
      OFFER: begin
        if (sched.sched_ack) begin
          state_n = BUSY;
          rr_ptr_n = task_id + TASK_ID_W'(1);
          cnt_n = sched_grant_count == GRANT_MAX ? sched_grant_count : sched_grant_count + 16'd1;
          timer_n = '0;
        end else if (!req[task_id]) state_n = IDLE;
      end
      BUSY: begin
        timer_n = timer + TIMER_W'(1);
        if (sched.comp_done) state_n = IDLE;
        else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          timeout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      task_id <= '0;
      timer <= '0;
      sched_grant_count <= '0;
      sched_timeout <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      task_id <= task_id_n;
      timer <= timer_n;
      sched_grant_count <= cnt_n;
      sched_timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_comp_task_scheduler.sv
// tb_comp_task_scheduler: directed checks of rotation, withdrawal, watchdog, reset and saturation
module tb_comp_task_scheduler;
  localparam int GMAX = 20;
  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] en, rdy, ck;
  logic clear, timeout;
  logic [15:0] cnt;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  comp_task_scheduler_if #(.TASK_ID_W(4)) bus();
  comp_task_scheduler #(
    .NUM_TASKS(16), .TASK_ID_W(4), .TIMEOUT_CYCLES(8), .TIMER_W(4), .GRANT_MAX(16'(GMAX))
  ) dut (
    .clk(clk), .reset_n(reset_n), .task_enable(en), .oflow_fprints_ready(rdy),
    .fprint_checkin(ck), .sched(bus), .sched_timeout(timeout), .timeout_clear(clear),
    .sched_grant_count(cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic take(input int id);
    chk("offer_valid", 32'(bus.sched_valid), 1);
    chk("offer_id", 32'(bus.sched_task_id), id);
    bus.sched_ack = 1'b1;
    tick;
    bus.sched_ack = 1'b0;
    exp_cnt = exp_cnt == GMAX ? GMAX : exp_cnt + 1;
    chk("busy", 32'(bus.sched_busy), 1);
    chk("busy_valid", 32'(bus.sched_valid), 0);
    chk("grant_cnt", 32'(cnt), exp_cnt);
  endtask
  task automatic serve(input int id);
    take(id);
    bus.comp_done = 1'b1;
    tick;
    bus.comp_done = 1'b0;
    chk("done_idle", 32'(bus.sched_busy), 0);
    chk("done_valid", 32'(bus.sched_valid), 0);
  endtask
  initial begin
    reset_n = 1'b0;
    en = 16'hFFFF;
    rdy = '0;
    ck = '0;
    clear = 1'b0;
    bus.sched_ack = 1'b0;
    bus.comp_done = 1'b0;
    tick;
    tick;
    chk("rst_valid", 32'(bus.sched_valid), 0);
    chk("rst_id", 32'(bus.sched_task_id), 0);
    chk("rst_busy", 32'(bus.sched_busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cnt", 32'(cnt), 0);
    reset_n = 1'b1;
    tick;
    rdy = 16'h0088;
    tick;
    serve(3);
    tick;
    serve(7);
    tick;
    rdy = '0;
    serve(3);
    chk("cnt_three", 32'(cnt), 3);
    rdy = 16'h4000;
    tick;
    rdy = '0;
    serve(14);
    rdy = 16'h8000;
    ck = 16'h0001;
    tick;
    serve(15);
    tick;
    rdy = '0;
    ck = '0;
    serve(0);
    rdy = 16'h0020;
    tick;
    chk("wd_valid", 32'(bus.sched_valid), 1);
    chk("wd_id", 32'(bus.sched_task_id), 5);
    rdy = '0;
    tick;
    chk("wd_drop", 32'(bus.sched_valid), 0);
    chk("wd_hold_id", 32'(bus.sched_task_id), 5);
    chk("wd_cnt", 32'(cnt), exp_cnt);
    rdy = 16'h0005;
    tick;
    rdy = '0;
    serve(2);
    rdy = 16'h0200;
    tick;
    rdy = '0;
    take(9);
    repeat (7) tick;
    chk("to_busy7", 32'(bus.sched_busy), 1);
    chk("to_not_yet", 32'(timeout), 0);
    tick;
    chk("to_set", 32'(timeout), 1);
    chk("to_idle", 32'(bus.sched_busy), 0);
    tick;
    chk("to_sticky", 32'(timeout), 1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("to_clear", 32'(timeout), 0);
    rdy = 16'h0200;
    tick;
    rdy = '0;
    take(9);
    repeat (7) tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("to_set_wins", 32'(timeout), 1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("to_clear2", 32'(timeout), 0);
    rdy = 16'h0200;
    tick;
    rdy = '0;
    take(9);
    repeat (7) tick;
    bus.comp_done = 1'b1;
    tick;
    bus.comp_done = 1'b0;
    chk("done_beats_to", 32'(timeout), 0);
    chk("done_beats_idle", 32'(bus.sched_busy), 0);
    en = 16'hFFF7;
    rdy = 16'h0008;
    tick;
    tick;
    chk("masked", 32'(bus.sched_valid), 0);
    en = 16'hFFFF;
    tick;
    take(3);
    reset_n = 1'b0;
    tick;
    exp_cnt = 0;
    chk("mid_rst_valid", 32'(bus.sched_valid), 0);
    chk("mid_rst_busy", 32'(bus.sched_busy), 0);
    chk("mid_rst_id", 32'(bus.sched_task_id), 0);
    chk("mid_rst_cnt", 32'(cnt), 0);
    reset_n = 1'b1;
    rdy = '0;
    tick;
    for (int i = 0; i < GMAX + 3; i++) begin
      rdy = 16'h0002;
      tick;
      rdy = '0;
      serve(1);
    end
    chk("sat_cnt", 32'(cnt), GMAX);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
